// File: rtl/fc_port_fsm_pkg.sv
// Shared types and primitive constants for the Fibre Channel port state machine.
package fc_port_fsm_pkg;

    // Ordered-set lead byte: K28.5 in [31:24], remaining bytes data.
    localparam logic [3:0] K_LEAD = 4'b1000;

    localparam logic [31:0] NOS  = 32'hBC55BF45;
    localparam logic [31:0] OLS  = 32'hBC358A55;
    localparam logic [31:0] LR   = 32'hBC49BF49;
    localparam logic [31:0] LRR  = 32'hBC35BF49;
    localparam logic [31:0] IDLE = 32'hBC95B5B5;

    typedef enum logic [3:0] {
        OL1 = 4'd0,
        OL2 = 4'd1,
        LR1 = 4'd2,
        LR2 = 4'd3,
        LR3 = 4'd4,
        LF1 = 4'd5,
        LF2 = 4'd6,
        AC  = 4'd7
    } port_state_t;

    typedef enum logic [2:0] {
        SEQ_NONE = 3'd0,
        SEQ_NOS  = 3'd1,
        SEQ_OLS  = 3'd2,
        SEQ_LR   = 3'd3,
        SEQ_LRR  = 3'd4,
        SEQ_IDLE = 3'd5
    } seq_t;

    function automatic logic [35:0] os_word(input logic [31:0] prim);
        return {K_LEAD, prim};
    endfunction

    // Maps a 36-bit word to the ordered set it carries, or SEQ_NONE.
    function automatic seq_t classify(input logic [35:0] w);
        seq_t s;
        s = SEQ_NONE;
        if (w[35:32] == K_LEAD) begin
            case (w[31:0])
                NOS:     s = SEQ_NOS;
                OLS:     s = SEQ_OLS;
                LR:      s = SEQ_LR;
                LRR:     s = SEQ_LRR;
                IDLE:    s = SEQ_IDLE;
                default: s = SEQ_NONE;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/fc_port_fsm_seq_detect.sv
// Primitive-sequence detector: reports an ordered set once it has been seen
// SEQ_RECOG_COUNT times in a row, and keeps reporting it until the run breaks.
module fc_seq_detect
    import fc_port_fsm_pkg::*;
#(
    parameter int SEQ_RECOG_COUNT = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [35:0] rx_data_i,
    input  logic        rx_valid_i,
    input  logic        aligned_i,
    output seq_t        rx_seq_o
);

    localparam int CW = $clog2(SEQ_RECOG_COUNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SEQ_RECOG_COUNT);

    logic [CW-1:0] count_q;
    seq_t          last_q;
    seq_t          cls;

    assign cls = classify(rx_data_i);

    // Run-length of identical ordered sets; idle cycles while aligned hold the run.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            last_q  <= SEQ_NONE;
        end else if (rx_valid_i) begin
            if (cls == SEQ_NONE) begin
                count_q <= '0;
                last_q  <= SEQ_NONE;
            end else if (cls == last_q && count_q != '0) begin
                if (count_q != CNT_MAX) count_q <= count_q + CW'(1);
            end else begin
                count_q <= CW'(1);
                last_q  <= cls;
            end
        end else if (!aligned_i) begin
            count_q <= '0;
            last_q  <= SEQ_NONE;
        end
    end

    assign rx_seq_o = (count_q == CNT_MAX) ? last_q : SEQ_NONE;

endmodule

// File: rtl/fc_port_fsm.sv
// Fibre Channel port state machine: sequences Offline / Link Recovery /
// Link Failure / Active from received primitive sequences and selects the
// word sent to the transceiver each cycle.
module fc_port_fsm
    import fc_port_fsm_pkg::*;
#(
    parameter int R_T_TOV_CYCLES   = 21250000,
    parameter int SYNC_LOSS_CYCLES = 64,
    parameter int SEQ_RECOG_COUNT  = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [35:0] rx_data_i,
    input  logic        rx_valid_i,
    input  logic        aligned_i,
    input  logic [35:0] src_data_i,
    input  logic        src_valid_i,
    output logic        src_ready_o,
    output logic [35:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic        link_reset_req_i,
    input  logic        offline_req_i,
    output logic [3:0]  state_o,
    output logic        link_up_o,
    output logic [15:0] lr_count_o
);

    localparam int SW = $clog2(SYNC_LOSS_CYCLES + 1);
    localparam logic [SW-1:0] SYNC_MAX = SW'(SYNC_LOSS_CYCLES);
    localparam logic [31:0]   TOV_LAST = 32'(R_T_TOV_CYCLES - 1);

    port_state_t   state_q, state_d;
    seq_t          rx_seq;
    logic [31:0]   timer_q;
    logic [SW-1:0] sync_cnt_q;
    logic          sync_lost;
    logic          timeout;
    logic          timer_run;
    logic [35:0]   tx_word;
    logic [35:0]   tx_data_q;
    logic          tx_valid_q;
    logic          link_up_q;
    logic [15:0]   lr_count_q;

    fc_seq_detect #(.SEQ_RECOG_COUNT(SEQ_RECOG_COUNT)) u_seq_detect (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .aligned_i  (aligned_i),
        .rx_seq_o   (rx_seq)
    );

    assign sync_lost = (sync_cnt_q >= SYNC_MAX);
    assign timeout   = (timer_q == TOV_LAST);
    assign timer_run = (state_q == LR1) || (state_q == LR2) ||
                       (state_q == LR3) || (state_q == OL2);

    // Next-state selection; the order of tests inside each state is the priority.
    always_comb begin
        state_d = state_q;
        if (offline_req_i) begin
            state_d = OL1;
        end else begin
            case (state_q)
                OL1: begin
                    if      (rx_seq == SEQ_OLS) state_d = OL2;
                    else if (rx_seq == SEQ_LR)  state_d = LR2;
                    else if (rx_seq == SEQ_NOS) state_d = LF1;
                end
                OL2, LR1: begin
                    if      (rx_seq == SEQ_LRR) state_d = LR3;
                    else if (rx_seq == SEQ_LR)  state_d = LR2;
                    else if (sync_lost)         state_d = LF1;
                    else if (timeout)           state_d = LF2;
                end
                LR2: begin
                    if      (rx_seq == SEQ_IDLE) state_d = AC;
                    else if (rx_seq == SEQ_LRR)  state_d = LR3;
                    else if (rx_seq == SEQ_NOS)  state_d = LF1;
                    else if (sync_lost)          state_d = LF1;
                    else if (timeout)            state_d = LF2;
                end
                LR3: begin
                    if      (rx_seq == SEQ_IDLE) state_d = AC;
                    else if (rx_seq == SEQ_LR)   state_d = LR2;
                    else if (sync_lost)          state_d = LF1;
                    else if (timeout)            state_d = LF2;
                end
                AC: begin
                    if (sync_lost || rx_seq == SEQ_NOS) state_d = LF1;
                    else if (rx_seq == SEQ_OLS)         state_d = OL2;
                    else if (rx_seq == SEQ_LR)          state_d = LR2;
                    else if (link_reset_req_i)          state_d = LR1;
                end
                LF1, LF2: begin
                    if      (rx_seq == SEQ_OLS) state_d = OL2;
                    else if (rx_seq == SEQ_LR)  state_d = LR2;
                end
                default: state_d = OL1;
            endcase
        end
    end

    // Word for the current state; in AC the upstream stream passes through.
    always_comb begin
        tx_word = os_word(OLS);
        case (state_q)
            OL1:     tx_word = os_word(OLS);
            OL2:     tx_word = os_word(LR);
            LR1:     tx_word = os_word(LR);
            LR2:     tx_word = os_word(LRR);
            LR3:     tx_word = os_word(IDLE);
            LF1:     tx_word = os_word(OLS);
            LF2:     tx_word = os_word(NOS);
            AC:      tx_word = src_valid_i ? src_data_i : os_word(IDLE);
            default: tx_word = os_word(OLS);
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= OL1;
            tx_data_q  <= os_word(OLS);
            tx_valid_q <= 1'b0;
            link_up_q  <= 1'b0;
            lr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= 1'b1;
            link_up_q  <= (state_d == AC);
            if (tx_ready_i) tx_data_q <= tx_word;
            if (state_d != state_q && (state_d == LR1 || state_d == LR2) &&
                lr_count_q != 16'hFFFF)
                lr_count_q <= lr_count_q + 16'd1;
        end
    end

    // R_T_TOV timer: restarts on every state change, advances only in recovery/OL2.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                 timer_q <= '0;
        else if (state_d != state_q) timer_q <= '0;
        else if (timer_run && !timeout) timer_q <= timer_q + 32'd1;
    end

    // Consecutive cycles without word alignment, saturating at the loss threshold.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)             sync_cnt_q <= '0;
        else if (aligned_i)      sync_cnt_q <= '0;
        else if (!sync_lost)     sync_cnt_q <= sync_cnt_q + SW'(1);
    end

    assign src_ready_o = (state_q == AC) && tx_ready_i;
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign state_o     = state_q;
    assign link_up_o   = link_up_q;
    assign lr_count_o  = lr_count_q;

endmodule

// File: tb/tb_fc_port_fsm.sv
// Directed bench for fc_port_fsm with a shortened R_T_TOV.
module tb_fc_port_fsm;
    import fc_port_fsm_pkg::*;

    localparam logic [35:0] W_NOS  = 36'h8BC55BF45;
    localparam logic [35:0] W_OLS  = 36'h8BC358A55;
    localparam logic [35:0] W_LR   = 36'h8BC49BF49;
    localparam logic [35:0] W_LRR  = 36'h8BC35BF49;
    localparam logic [35:0] W_IDLE = 36'h8BC95B5B5;
    localparam logic [35:0] W_DATA = 36'h012345678;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [35:0] rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        aligned_i = 1'b1;
    logic [35:0] src_data_i = '0;
    logic        src_valid_i = 1'b0;
    logic        src_ready_o;
    logic [35:0] tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic        link_reset_req_i = 1'b0;
    logic        offline_req_i = 1'b0;
    logic [3:0]  state_o;
    logic        link_up_o;
    logic [15:0] lr_count_o;

    int errors = 0;
    int checks = 0;

    fc_port_fsm #(.R_T_TOV_CYCLES(100), .SYNC_LOSS_CYCLES(64), .SEQ_RECOG_COUNT(3)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .rx_data_i        (rx_data_i),
        .rx_valid_i       (rx_valid_i),
        .aligned_i        (aligned_i),
        .src_data_i       (src_data_i),
        .src_valid_i      (src_valid_i),
        .src_ready_o      (src_ready_o),
        .tx_data_o        (tx_data_o),
        .tx_valid_o       (tx_valid_o),
        .tx_ready_i       (tx_ready_i),
        .link_reset_req_i (link_reset_req_i),
        .offline_req_i    (offline_req_i),
        .state_o          (state_o),
        .link_up_o        (link_up_o),
        .lr_count_o       (lr_count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic feed(input logic [35:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            rx_data_i  = w;
            rx_valid_i = 1'b1;
            step();
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step();
        step();
        checks++; if (state_o !== OL1) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_o, OL1); end
        checks++; if (tx_data_o !== W_OLS) begin errors++; $display("FAIL reset_tx_data: got %h want %h", tx_data_o, W_OLS); end
        checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid_o); end
        checks++; if (src_ready_o !== 1'b0) begin errors++; $display("FAIL reset_src_ready: got %b want 0", src_ready_o); end
        checks++; if (link_up_o !== 1'b0) begin errors++; $display("FAIL reset_link_up: got %b want 0", link_up_o); end
        checks++; if (lr_count_o !== 16'd0) begin errors++; $display("FAIL reset_lr_count: got %0d want 0", lr_count_o); end
        reset_i = 1'b0;
        step();
        checks++; if (tx_valid_o !== 1'b1) begin errors++; $display("FAIL tx_valid_after_reset: got %b want 1", tx_valid_o); end
    endtask

    task automatic test_bringup();
        feed(W_OLS, 3);
        checks++; if (state_o !== OL1) begin errors++; $display("FAIL bringup_ol1_hold: got %0d want %0d", state_o, OL1); end
        step();
        checks++; if (state_o !== OL2) begin errors++; $display("FAIL bringup_ol2: got %0d want %0d", state_o, OL2); end
        checks++; if (tx_data_o !== W_OLS) begin errors++; $display("FAIL bringup_tx_lag: got %h want %h", tx_data_o, W_OLS); end
        step();
        checks++; if (tx_data_o !== W_LR) begin errors++; $display("FAIL bringup_tx_lr: got %h want %h", tx_data_o, W_LR); end
        feed(W_LRR, 3);
        step();
        checks++; if (state_o !== LR3) begin errors++; $display("FAIL bringup_lr3: got %0d want %0d", state_o, LR3); end
        step();
        checks++; if (tx_data_o !== W_IDLE) begin errors++; $display("FAIL bringup_tx_idle: got %h want %h", tx_data_o, W_IDLE); end
        feed(W_IDLE, 3);
        step();
        checks++; if (state_o !== AC) begin errors++; $display("FAIL bringup_ac: got %0d want %0d", state_o, AC); end
        checks++; if (link_up_o !== 1'b1) begin errors++; $display("FAIL bringup_link_up: got %b want 1", link_up_o); end
        checks++; if (src_ready_o !== 1'b1) begin errors++; $display("FAIL bringup_src_ready_hi: got %b want 1", src_ready_o); end
        tx_ready_i = 1'b0;
        #1;
        checks++; if (src_ready_o !== 1'b0) begin errors++; $display("FAIL bringup_src_ready_lo: got %b want 0", src_ready_o); end
        tx_ready_i = 1'b1;
        #1;
    endtask

    task automatic test_lr_in_ac();
        feed(W_LR, 2);
        feed(W_DATA, 1);
        step();
        step();
        checks++; if (state_o !== AC) begin errors++; $display("FAIL broken_lr_run: got %0d want %0d", state_o, AC); end
        feed(W_LR, 3);
        checks++; if (state_o !== AC) begin errors++; $display("FAIL lr_run_hold: got %0d want %0d", state_o, AC); end
        step();
        checks++; if (state_o !== LR2) begin errors++; $display("FAIL lr_run_lr2: got %0d want %0d", state_o, LR2); end
        checks++; if (src_ready_o !== 1'b0) begin errors++; $display("FAIL lr_run_src_ready: got %b want 0", src_ready_o); end
        checks++; if (lr_count_o !== 16'd1) begin errors++; $display("FAIL lr_run_count: got %0d want 1", lr_count_o); end
        checks++; if (link_up_o !== 1'b0) begin errors++; $display("FAIL lr_run_link_up: got %b want 0", link_up_o); end
        step();
        checks++; if (tx_data_o !== W_LRR) begin errors++; $display("FAIL lr_run_tx_lrr: got %h want %h", tx_data_o, W_LRR); end
        feed(W_IDLE, 3);
        step();
        checks++; if (state_o !== AC) begin errors++; $display("FAIL lr_run_back_ac: got %0d want %0d", state_o, AC); end
    endtask

    task automatic test_timeout();
        feed(W_DATA, 1);
        link_reset_req_i = 1'b1;
        step();
        link_reset_req_i = 1'b0;
        checks++; if (state_o !== LR1) begin errors++; $display("FAIL tov_lr1: got %0d want %0d", state_o, LR1); end
        checks++; if (lr_count_o !== 16'd2) begin errors++; $display("FAIL tov_lr_count: got %0d want 2", lr_count_o); end
        repeat (99) step();
        checks++; if (state_o !== LR1) begin errors++; $display("FAIL tov_early: got %0d want %0d", state_o, LR1); end
        step();
        checks++; if (state_o !== LF2) begin errors++; $display("FAIL tov_lf2: got %0d want %0d", state_o, LF2); end
        step();
        checks++; if (tx_data_o !== W_NOS) begin errors++; $display("FAIL tov_tx_nos: got %h want %h", tx_data_o, W_NOS); end
        feed(W_OLS, 3);
        step();
        checks++; if (state_o !== OL2) begin errors++; $display("FAIL tov_ol2: got %0d want %0d", state_o, OL2); end
        feed(W_LRR, 3);
        step();
        feed(W_IDLE, 3);
        step();
        checks++; if (state_o !== AC) begin errors++; $display("FAIL tov_back_ac: got %0d want %0d", state_o, AC); end
    endtask

    task automatic test_sync_loss();
        aligned_i = 1'b0;
        repeat (63) step();
        aligned_i = 1'b1;
        step();
        checks++; if (state_o !== AC) begin errors++; $display("FAIL sync63_hold: got %0d want %0d", state_o, AC); end
        aligned_i = 1'b0;
        repeat (64) step();
        checks++; if (state_o !== AC) begin errors++; $display("FAIL sync64_hold: got %0d want %0d", state_o, AC); end
        step();
        aligned_i = 1'b1;
        checks++; if (state_o !== LF1) begin errors++; $display("FAIL sync64_lf1: got %0d want %0d", state_o, LF1); end
        step();
        checks++; if (tx_data_o !== W_OLS) begin errors++; $display("FAIL sync_tx_ols: got %h want %h", tx_data_o, W_OLS); end
        feed(W_LR, 3);
        step();
        checks++; if (state_o !== LR2) begin errors++; $display("FAIL sync_lr2: got %0d want %0d", state_o, LR2); end
        checks++; if (lr_count_o !== 16'd3) begin errors++; $display("FAIL sync_lr_count: got %0d want 3", lr_count_o); end
        feed(W_IDLE, 3);
        step();
        checks++; if (state_o !== AC) begin errors++; $display("FAIL sync_back_ac: got %0d want %0d", state_o, AC); end
    endtask

    task automatic test_frame_backpressure();
        logic [35:0] frame [6];
        logic [35:0] exp_tx;
        int idx;
        int cyc;
        frame[0] = 36'h8BCB5D6D6;
        for (int i = 1; i < 6; i++) frame[i] = 36'h0A0000000 + 36'(i);
        exp_tx = W_IDLE;
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 30) begin
            src_valid_i = 1'b1;
            src_data_i  = frame[idx];
            tx_ready_i  = (cyc % 2 == 0);
            #1;
            checks++; if (src_ready_o !== tx_ready_i) begin errors++; $display("FAIL frame_src_ready cyc %0d: got %b want %b", cyc, src_ready_o, tx_ready_i); end
            step();
            if (tx_ready_i) begin
                exp_tx = frame[idx];
                idx++;
            end
            checks++; if (tx_data_o !== exp_tx) begin errors++; $display("FAIL frame_tx cyc %0d: got %h want %h", cyc, tx_data_o, exp_tx); end
            cyc++;
        end
        checks++; if (idx != 6) begin errors++; $display("FAIL frame_budget: got %0d words want 6", idx); end
        src_valid_i = 1'b0;
        tx_ready_i  = 1'b1;
        step();
        checks++; if (tx_data_o !== W_IDLE) begin errors++; $display("FAIL frame_idle_fill: got %h want %h", tx_data_o, W_IDLE); end
    endtask

    task automatic test_async_reset();
        src_valid_i = 1'b1;
        src_data_i  = 36'h0DEADBEEF;
        step();
        checks++; if (state_o !== AC) begin errors++; $display("FAIL areset_pre_ac: got %0d want %0d", state_o, AC); end
        #2;
        reset_i = 1'b1;
        #1;
        checks++; if (state_o !== OL1) begin errors++; $display("FAIL areset_state: got %0d want %0d", state_o, OL1); end
        checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL areset_tx_valid: got %b want 0", tx_valid_o); end
        checks++; if (src_ready_o !== 1'b0) begin errors++; $display("FAIL areset_src_ready: got %b want 0", src_ready_o); end
        checks++; if (tx_data_o !== W_OLS) begin errors++; $display("FAIL areset_tx_data: got %h want %h", tx_data_o, W_OLS); end
        checks++; if (lr_count_o !== 16'd0) begin errors++; $display("FAIL areset_lr_count: got %0d want 0", lr_count_o); end
        src_valid_i = 1'b0;
        step();
        reset_i = 1'b0;
        #1;
        checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL areset_release_valid: got %b want 0", tx_valid_o); end
        step();
        checks++; if (tx_valid_o !== 1'b1) begin errors++; $display("FAIL areset_valid_after: got %b want 1", tx_valid_o); end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lr_in_ac();
        test_timeout();
        test_sync_loss();
        test_frame_backpressure();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
